// File: rtl/add8_err_monitor.sv
// Error-characterisation engine: sweeps every operand pair through an attached
// approximate adder and accumulates error metrics. Define ADD8_ERR_MSE_EN to add sum_sq_err.
module add8_err_monitor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [WIDTH:0]       approx_sum,
    output logic                 busy,
    output logic                 done,
    output logic                 results_valid,
    output logic [3*WIDTH:0]     sum_abs_err,
    output logic [WIDTH:0]       wce,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH+3:0]   hd_sum
`ifdef ADD8_ERR_MSE_EN
    ,
    output logic [4*WIDTH+1:0]   sum_sq_err
`endif
);

    localparam int HD_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH:0]          exact_sum;
    logic signed [WIDTH+1:0] diff;
    logic signed [WIDTH+1:0] neg_diff;
    logic [WIDTH:0]          abs_err;
    logic [WIDTH:0]          xor_bits;
    logic [HD_W-1:0]         hd_bits;
    logic                    last_vec;
`ifdef ADD8_ERR_MSE_EN
    logic [2*WIDTH+1:0]      sq_err;
`endif

    // Error datapath for the operands currently presented to the adder.
    always_comb begin
        exact_sum = {1'b0, op_a} + {1'b0, op_b};
        diff      = signed'({1'b0, approx_sum}) - signed'({1'b0, exact_sum});
        neg_diff  = -diff;
        abs_err   = diff[WIDTH+1] ? neg_diff[WIDTH:0] : diff[WIDTH:0];
        xor_bits  = approx_sum ^ exact_sum;
        hd_bits   = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            hd_bits = hd_bits + HD_W'(xor_bits[i]);
        end
        last_vec  = &{op_b, op_a};
    end

`ifdef ADD8_ERR_MSE_EN
    assign sq_err = abs_err * abs_err;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (state == SWEEP) && (next_state == DONE);
        end
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = SWEEP;
            SWEEP:   if (abort) next_state = IDLE;
                     else if (last_vec) next_state = DONE;
            DONE:    if (start) next_state = SWEEP;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == SWEEP);
        results_valid = (state == DONE);
    end

    // Abort takes priority over the update, so an aborted cycle is not accumulated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            sum_abs_err <= '0;
            wce         <= '0;
            err_count   <= '0;
            hd_sum      <= '0;
`ifdef ADD8_ERR_MSE_EN
            sum_sq_err  <= '0;
`endif
        end else if (state == SWEEP) begin
            if (!abort) begin
                sum_abs_err  <= sum_abs_err + (3*WIDTH+1)'(abs_err);
                err_count    <= err_count + (2*WIDTH+1)'(abs_err != '0);
                hd_sum       <= hd_sum + (2*WIDTH+4)'(hd_bits);
                if (abs_err > wce) wce <= abs_err;
`ifdef ADD8_ERR_MSE_EN
                sum_sq_err   <= sum_sq_err + (4*WIDTH+2)'(sq_err);
`endif
                {op_b, op_a} <= {op_b, op_a} + 1'b1;
            end
        end else if (start) begin
            op_a        <= '0;
            op_b        <= '0;
            sum_abs_err <= '0;
            wce         <= '0;
            err_count   <= '0;
            hd_sum      <= '0;
`ifdef ADD8_ERR_MSE_EN
            sum_sq_err  <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor at WIDTH=4 (256-pair sweep) with a
// switchable adder stub: exact, LSB-drop, constant-zero, LSB-flip.
module tb_add8_err_monitor;

    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [W-1:0]     op_a, op_b;
    logic [W:0]       approx_sum;
    logic [W:0]       ex_sum;
    logic             busy, done, results_valid;
    logic [3*W:0]     sum_abs_err;
    logic [W:0]       wce;
    logic [2*W:0]     err_count;
    logic [2*W+3:0]   hd_sum;
`ifdef ADD8_ERR_MSE_EN
    logic [4*W+1:0]   sum_sq_err;
`endif
    int               mode;
    int               total = 0;
    int               bad = 0;
    int               done_seen;

    always #5 clk = ~clk;

    always_comb begin
        ex_sum = {1'b0, op_a} + {1'b0, op_b};
        case (mode)
            0:       approx_sum = ex_sum;
            1:       approx_sum = {ex_sum[W:1], 1'b0};
            2:       approx_sum = '0;
            default: approx_sum = {ex_sum[W:1], ~ex_sum[0]};
        endcase
    end

    add8_err_monitor #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .op_a          (op_a),
        .op_b          (op_b),
        .approx_sum    (approx_sum),
        .busy          (busy),
        .done          (done),
        .results_valid (results_valid),
        .sum_abs_err   (sum_abs_err),
        .wce           (wce),
        .err_count     (err_count),
        .hd_sum        (hd_sum)
`ifdef ADD8_ERR_MSE_EN
        ,
        .sum_sq_err    (sum_sq_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Full sweep with a start pulse injected mid-sweep; done must still land on the original cycle.
    task automatic do_sweep(input string tag, input int mid_start,
                            input longint e_abs, input longint e_wce, input longint e_err,
                            input longint e_hd, input longint e_sq);
        pulse_start();
        check({tag, "_busy_first"}, busy, 1);
        check({tag, "_op_first"}, {op_b, op_a}, 0);
        check({tag, "_valid_clr"}, results_valid, 0);
        for (int k = 1; k < N; k++) begin
            @(posedge clk);
            #1 start = (k == mid_start);
        end
        check({tag, "_busy_last"}, busy, 1);
        check({tag, "_done_early"}, done, 0);
        check({tag, "_op_last"}, {op_b, op_a}, N - 1);
        @(posedge clk);
        #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_valid"}, results_valid, 1);
        check({tag, "_abs"}, sum_abs_err, e_abs);
        check({tag, "_wce"}, wce, e_wce);
        check({tag, "_err"}, err_count, e_err);
        check({tag, "_hd"}, hd_sum, e_hd);
`ifdef ADD8_ERR_MSE_EN
        check({tag, "_sq"}, sum_sq_err, e_sq);
`else
        if (e_sq < 0) $display("note: negative squared-error expectation ignored");
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_valid_hold"}, results_valid, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", results_valid, 0);
        check("rst_ops", {op_b, op_a}, 0);
        check("rst_abs", sum_abs_err, 0);
        @(negedge clk) rst = 1'b0;

        // Exact stub, start pulsed mid-sweep.
        mode = 0;
        do_sweep("exact", 40, 0, 0, 0, 0, 0);

        // Constant-zero stub, restarted from DONE.
        mode = 2;
        do_sweep("zero", 0, 3840, 30, 255, 632, 68480);

        // LSB-drop stub, restarted from DONE: no carry-over from the zero sweep.
        mode = 1;
        do_sweep("lsb", 0, 128, 1, 128, 128, 128);

        // Abort mid-sweep.
        pulse_start();
        repeat (100) @(posedge clk);
        #1 abort = 1'b1;
        check("abort_busy_before", busy, 1);
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", results_valid, 0);
        done_seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1 if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        // Abort coinciding with the final vector wins.
        pulse_start();
        repeat (N - 1) @(posedge clk);
        #1 abort = 1'b1;
        check("abort_last_op", {op_b, op_a}, N - 1);
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_last_done", done, 0);
        check("abort_last_busy", busy, 0);
        check("abort_last_valid", results_valid, 0);

        // Fresh sweep after abort with LSB-flip stub.
        mode = 3;
        do_sweep("flip", 0, 256, 1, 256, 256, 256);

        // Reset mid-sweep clears outputs without waiting for an edge.
        mode = 2;
        pulse_start();
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_ops", {op_b, op_a}, 0);
        check("mrst_abs", sum_abs_err, 0);
        check("mrst_wce", wce, 0);
        check("mrst_err", err_count, 0);
        check("mrst_hd", hd_sum, 0);
        check("mrst_valid", results_valid, 0);
        @(negedge clk) rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1 if (done || busy) done_seen++;
        end
        check("mrst_idle", done_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
